regfile_mp: RTL and testbench

Parametrised multi-read-port register file, successor to the CPU's fixed two-port 32×32 register file. It provides one write port and NUM_RD read ports, each independently combinational or registered. A hardwired zero register is optional. After reset, a clear sequencer zeroes every entry in place of a file preload. It sits between decode (read addresses) and writeback (write port) of the datapath.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_rd_port.sv | 46 ++++
 rtl/regfile_mp.sv | 84 ++++++++
 tb/tb_regfile_mp.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_t;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

endpackage

// File: rtl/regfile_rd_port.sv
// One read port: storage mux, zero-register gate, write bypass, optional output register.
// Bypass behaviour follows REGFILE_BYPASS_EN (write-first when defined, read-before-write otherwise).
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter bit ZERO_REG = 1'b1,
  parameter bit IS_REG   = 1'b0
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    clearing_i,
  input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]      mem_i,
  input  logic                                    wr_en_i,
  input  logic [ADDR_W-1:0]                       wr_addr_i,
  input  logic [DATA_W-1:0]                       wr_data_i,
  input  logic [ADDR_W-1:0]                       addr_i,
  output logic [DATA_W-1:0]                       data_o
);

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] data_q;

  // wr_en_i is already qualified by READY and the zero-register filter
  always_comb begin
    rd_val = mem_i[addr_i];
    if (BYPASS && wr_en_i && (wr_addr_i == addr_i)) rd_val = wr_data_i;
    if (ZERO_REG && (addr_i == '0)) rd_val = '0;
    if (clearing_i) rd_val = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) data_q <= '0;
    else     data_q <= rd_val;
  end

  assign data_o = IS_REG ? data_q : rd_val;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with post-reset clear sweep; one write port, NUM_RD read ports.
// Optional same-cycle write-first bypass enabled by macro REGFILE_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int                DATA_W      = RF_DATA_W,
  parameter int                ADDR_W      = RF_ADDR_W,
  parameter int                NUM_RD      = 2,
  parameter logic [NUM_RD-1:0] RD_REG_MASK = 2'b10,
  parameter bit                ZERO_REG    = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     write_enable,
  input  logic [ADDR_W-1:0]        addr_w,
  input  logic [DATA_W-1:0]        data_w,
  input  logic [NUM_RD*ADDR_W-1:0] addr_r,
  output logic [NUM_RD*DATA_W-1:0] data_r,
  output logic                     init_busy
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] mem_q;
  rf_state_t                    state_q, state_d;
  logic [ADDR_W-1:0]            clr_ptr_q, clr_ptr_d;
  logic                         clearing;
  logic                         wr_hit;

  assign clearing  = (state_q == RF_CLEAR);
  assign init_busy = clearing;
  assign wr_hit    = !clearing && write_enable && !(ZERO_REG && (addr_w == '0));

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      RF_CLEAR: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == {ADDR_W{1'b1}}) state_d = RF_READY;
      end
      RF_READY: state_d = RF_READY;
      default:  state_d = RF_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RF_CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Storage has no reset of its own; the sweep zeroes it once rst drops
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clearing)    mem_q[clr_ptr_q] <= '0;
      else if (wr_hit) mem_q[addr_w]    <= data_w;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .IS_REG   (RD_REG_MASK[i])
    ) u_port (
      .clk        (clk),
      .rst        (rst),
      .clearing_i (clearing),
      .mem_i      (mem_q),
      .wr_en_i    (wr_hit),
      .wr_addr_i  (addr_w),
      .wr_data_i  (data_w),
      .addr_i     (addr_r[i*ADDR_W +: ADDR_W]),
      .data_o     (data_r[i*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised bench for regfile_mp: default 2-port build against an array model, plus a 4-port narrow build.
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [3:0] B_MASK = 4'b0101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default build
  logic        rst_a = 1'b1, we_a = 1'b0, busy_a;
  logic [4:0]  aw_a = '0;
  logic [31:0] dw_a = '0;
  logic [9:0]  ar_a = '0;
  logic [63:0] dr_a;

  // narrow four-port build
  logic        rst_b = 1'b1, we_b = 1'b0, busy_b;
  logic [2:0]  aw_b = '0;
  logic [15:0] dw_b = '0;
  logic [11:0] ar_b = '0;
  logic [63:0] dr_b;

  regfile_mp u_dut_a (
    .clk(clk), .rst(rst_a), .write_enable(we_a), .addr_w(aw_a), .data_w(dw_a),
    .addr_r(ar_a), .data_r(dr_a), .init_busy(busy_a)
  );

  regfile_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .RD_REG_MASK(4'b0101), .ZERO_REG(1'b1)) u_dut_b (
    .clk(clk), .rst(rst_b), .write_enable(we_b), .addr_w(aw_b), .data_w(dw_b),
    .addr_r(ar_b), .data_r(dr_b), .init_busy(busy_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model for the default build
  logic [31:0] model_mem [32];
  int          clear_left  = 0;
  bit          model_valid = 0;
  logic [31:0] exp_reg1    = '0;
  logic [31:0] obs0, obs1_post;

  function automatic logic [31:0] exp_comb_a(input logic [4:0] ra, input logic we,
                                             input logic [4:0] aw, input logic [31:0] dw);
    if (clear_left > 0) return 32'h0;
    if (ra == 5'd0) return 32'h0;
    if (BYP && we && (aw == ra)) return dw;
    return model_mem[ra];
  endfunction

  task automatic step_a(input logic r, input logic we, input logic [4:0] aw,
                        input logic [31:0] dw, input logic [4:0] ra0, input logic [4:0] ra1);
    logic [31:0] nxt_reg1;
    @(negedge clk);
    rst_a = r; we_a = we; aw_a = aw; dw_a = dw; ar_a = {ra1, ra0};
    #1;
    obs0 = dr_a[31:0];
    if (model_valid) begin
      check_eq("a_p0_comb", {32'h0, dr_a[31:0]}, {32'h0, exp_comb_a(ra0, we, aw, dw)});
      check_eq("a_p1_reg_hold", {32'h0, dr_a[63:32]}, {32'h0, exp_reg1});
    end
    nxt_reg1 = r ? 32'h0 : exp_comb_a(ra1, we, aw, dw);
    @(posedge clk);
    #1;
    if (r) begin
      for (int k = 0; k < 32; k++) model_mem[k] = 32'h0;
      clear_left = 32;
    end else if (clear_left > 0) begin
      clear_left--;
    end else if (we && aw != 5'd0) begin
      model_mem[aw] = dw;
    end
    exp_reg1    = nxt_reg1;
    model_valid = 1;
    obs1_post   = dr_a[63:32];
    check_eq("a_busy", {63'h0, busy_a}, {63'h0, clear_left > 0});
    check_eq("a_p1_reg", {32'h0, dr_a[63:32]}, {32'h0, exp_reg1});
  endtask

  task automatic count_sweep_a(input string tag, input logic we);
    int n = 0;
    while (busy_a && n < 100) begin
      step_a(1'b0, we, 5'd5, 32'h5, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      n++;
    end
    check_eq(tag, 64'(n), 64'd32);
  endtask

  logic [15:0] memb [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0]  aw, ra0, ra1;
    logic [2:0]  pa [4];
    logic [2:0]  pprev [4];
    int          nb;
    int          s;

    // ---------------- default build ----------------
    step_a(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    count_sweep_a("a_first_clear_len", 1'b0);
    for (int k = 0; k < 32; k++) step_a(1'b0, 1'b1, 5'(k), $urandom, 5'(k), 5'((k + 1) % 32));

    step_a(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    count_sweep_a("a_clear_len", 1'b1);
    step_a(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    check_eq("a_sweep_wr_lost", {32'h0, obs0}, 64'h0);
    for (int k = 0; k < 32; k += 2) step_a(1'b0, 1'b0, 5'd0, 32'h0, 5'(k), 5'(k + 1));

    step_a(1'b0, 1'b1, 5'd7, 32'hDEADBEEF, 5'd0, 5'd0);
    step_a(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    check_eq("a_basic_comb", {32'h0, obs0}, 64'hDEADBEEF);
    check_eq("a_basic_reg", {32'h0, obs1_post}, 64'hDEADBEEF);

    step_a(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    step_a(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    check_eq("a_zero_comb", {32'h0, obs0}, 64'h0);
    check_eq("a_zero_reg", {32'h0, obs1_post}, 64'h0);

    step_a(1'b0, 1'b1, 5'd3, 32'hAAAA, 5'd0, 5'd0);
    step_a(1'b0, 1'b1, 5'd3, 32'h1234, 5'd3, 5'd3);
    check_eq("a_hazard_comb", {32'h0, obs0}, BYP ? 64'h1234 : 64'hAAAA);
    check_eq("a_hazard_reg", {32'h0, obs1_post}, BYP ? 64'h1234 : 64'hAAAA);

    step_a(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    for (int k = 0; k < 10; k++) step_a(1'b0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
    step_a(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    count_sweep_a("a_midsweep_clear_len", 1'b0);

    for (int k = 0; k < 400; k++) begin
      aw  = 5'($urandom_range(0, 31));
      ra0 = ($urandom_range(0, 3) == 0) ? aw : 5'($urandom_range(0, 31));
      ra1 = ($urandom_range(0, 3) == 0) ? aw : 5'($urandom_range(0, 31));
      step_a(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), aw, $urandom, ra0, ra1);
    end

    // ---------------- four-port narrow build ----------------
    @(negedge clk); rst_b = 1'b1;
    @(posedge clk); #1;
    check_eq("b_reset_busy", {63'h0, busy_b}, 64'h1);
    check_eq("b_reset_p0_reg", {48'h0, dr_b[15:0]}, 64'h0);
    check_eq("b_reset_p2_reg", {48'h0, dr_b[47:32]}, 64'h0);
    @(negedge clk); rst_b = 1'b0;
    nb = 1;
    @(posedge clk); #1;
    while (busy_b && nb < 100) begin
      @(posedge clk); #1;
      nb++;
    end
    check_eq("b_clear_len", 64'(nb), 64'd8);

    memb[0] = 16'h0;
    for (int k = 1; k < 8; k++) begin
      memb[k] = 16'($urandom);
      @(negedge clk); we_b = 1'b1; aw_b = 3'(k); dw_b = memb[k];
      @(posedge clk); #1;
    end
    @(negedge clk); we_b = 1'b1; aw_b = 3'd0; dw_b = 16'hFFFF;
    @(posedge clk); #1;
    @(negedge clk); we_b = 1'b0;
    @(posedge clk); #1;

    for (int j = 0; j < 4; j++) pprev[j] = 3'd0;
    for (int t = 0; t < 8; t++) begin
      s = $urandom_range(0, 7);
      for (int j = 0; j < 4; j++) pa[j] = 3'((s + j * (1 + t % 2)) % 8);
      @(negedge clk);
      ar_b = {pa[3], pa[2], pa[1], pa[0]};
      #1;
      for (int j = 0; j < 4; j++)
        check_eq(B_MASK[j] ? "b_reg_hold" : "b_comb", {48'h0, dr_b[j*16 +: 16]},
                 {48'h0, B_MASK[j] ? memb[pprev[j]] : memb[pa[j]]});
      @(posedge clk); #1;
      for (int j = 0; j < 4; j++) begin
        check_eq("b_after_edge", {48'h0, dr_b[j*16 +: 16]}, {48'h0, memb[pa[j]]});
        pprev[j] = pa[j];
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
